// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package : aes_pkg
// Brief   : Shared types and constants for the AES-128 key schedule.
// Rev     : 1.0  initial release
// ============================================================================
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        SUB  = 2'd2,
        MIX  = 2'd3
    } state_t;

    localparam logic [7:0] AES_RCON_INIT     = 8'h01;
    localparam logic [7:0] AES_RCON_POLY     = 8'h1b;
    localparam logic [3:0] AES128_LAST_ROUND = 4'd10;

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_RCON_POLY : 8'h00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/FORWARD_SUBSTITUTION_BOX.sv
`default_nettype none
// ============================================================================
// Module  : FORWARD_SUBSTITUTION_BOX
// Brief   : AES forward S-box, registered lookup with one cycle of latency.
// Rev     : 1.0  initial release
// ============================================================================
module FORWARD_SUBSTITUTION_BOX (
    input  logic       clk,
    input  logic [7:0] a,
    output logic [7:0] c
);

    logic [127:0] w_row;

    // Each constant is one S-box row (high nibble); byte 0 sits in the MSBs.
    always_comb begin
        w_row = 128'h0;
        case (a[7:4])
            4'h0:    w_row = 128'h637c777bf26b6fc53001672bfed7ab76;
            4'h1:    w_row = 128'hca82c97dfa5947f0add4a2af9ca472c0;
            4'h2:    w_row = 128'hb7fd9326363ff7cc34a5e5f171d83115;
            4'h3:    w_row = 128'h04c723c31896059a071280e2eb27b275;
            4'h4:    w_row = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
            4'h5:    w_row = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
            4'h6:    w_row = 128'hd0efaafb434d338545f9027f503c9fa8;
            4'h7:    w_row = 128'h51a3408f929d38f5bcb6da2110fff3d2;
            4'h8:    w_row = 128'hcd0c13ec5f974417c4a77e3d645d1973;
            4'h9:    w_row = 128'h60814fdc222a908846eeb814de5e0bdb;
            4'ha:    w_row = 128'he0323a0a4906245cc2d3ac629195e479;
            4'hb:    w_row = 128'he7c8376d8dd54ea96c56f4ea657aae08;
            4'hc:    w_row = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
            4'hd:    w_row = 128'h703eb5664803f60e613557b986c11d9e;
            4'he:    w_row = 128'he1f8981169d98e949b1e87e9ce5528df;
            default: w_row = 128'h8ca1890dbfe6426841992d0fb054bb16;
        endcase
    end

    always_ff @(posedge clk) begin
        c <= w_row[{~a[3:0], 3'b000} +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/aes128_key_expansion.sv
`default_nettype none
// ============================================================================
// Module  : aes128_key_expansion
// Brief   : Sequential AES-128 key schedule streaming round keys 0..10.
// Rev     : 1.0  initial release
// ============================================================================
module aes128_key_expansion
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = int'(AES128_LAST_ROUND)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    localparam logic [3:0] c_LAST_RND = 4'(NUM_ROUNDS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_w0, r_w1, r_w2, r_w3;
    logic [3:0]  r_rnd;
    logic [7:0]  r_rcon;
    logic        r_busy;
    logic        r_done;

    logic        w_hs;
    logic        w_last;
    logic [31:0] w_sbox_addr;
    logic [31:0] w_sbox_out;
    logic [31:0] w_t, w_n0, w_n1, w_n2, w_n3;

    assign w_hs   = (r_state == EMIT) && rk_ready;
    assign w_last = (r_rnd == c_LAST_RND);

    // RotWord(w3) feeds the boxes; w3 is stable throughout SUB.
    assign w_sbox_addr = {r_w3[23:0], r_w3[31:24]};

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        FORWARD_SUBSTITUTION_BOX u_sbox (
            .clk (clk),
            .a   (w_sbox_addr[8*gi +: 8]),
            .c   (w_sbox_out[8*gi +: 8])
        );
    end

    assign w_t  = w_sbox_out ^ {r_rcon, 24'h000000};
    assign w_n0 = r_w0 ^ w_t;
    assign w_n1 = r_w1 ^ w_n0;
    assign w_n2 = r_w2 ^ w_n1;
    assign w_n3 = r_w3 ^ w_n2;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = EMIT;
            EMIT:    if (w_hs)   w_state_nxt = w_last ? IDLE : SUB;
            SUB:                 w_state_nxt = MIX;
            MIX:                 w_state_nxt = EMIT;
            default:             w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_w0    <= 32'h0;
            r_w1    <= 32'h0;
            r_w2    <= 32'h0;
            r_w3    <= 32'h0;
            r_rnd   <= 4'd0;
            r_rcon  <= AES_RCON_INIT;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_hs && w_last;
            if (r_state == IDLE && start) begin
                {r_w0, r_w1, r_w2, r_w3} <= key;
                r_rnd  <= 4'd0;
                r_rcon <= AES_RCON_INIT;
                r_busy <= 1'b1;
            end
            if (w_hs && w_last) begin
                r_busy <= 1'b0;
            end
            if (r_state == MIX) begin
                r_w0   <= w_n0;
                r_w1   <= w_n1;
                r_w2   <= w_n2;
                r_w3   <= w_n3;
                r_rnd  <= r_rnd + 4'd1;
                r_rcon <= xtime(r_rcon);
            end
        end
    end

    assign rk_valid = (r_state == EMIT);
    assign rk_data  = {r_w0, r_w1, r_w2, r_w3};
    assign rk_round = r_rnd;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_aes128_key_expansion.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes128_key_expansion
// Brief   : Directed self-checking bench for the AES-128 key schedule.
// Rev     : 1.0  initial release
// ============================================================================
module tb_aes128_key_expansion;

    localparam logic [127:0] c_KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_ALT  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_EXP1 [11] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam int c_BUDGET = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int           cyc = 0;
    int           checks = 0;
    int           passed = 0;
    int           start_cyc, r0_cyc, r10_cyc, done_cyc, n_hs;
    logic [127:0] got [11];

    aes128_key_expansion u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_start(input logic [127:0] k);
        start     = 1'b1;
        key       = k;
        start_cyc = cyc;
        tick();
        start     = 1'b0;
    endtask

    // Runs one schedule to its done pulse, starting at the sample after start.
    task automatic collect(input bit rand_ready, input bit inject);
        bit           hold_pending = 1'b0;
        logic [127:0] held_d = '0;
        logic [3:0]   held_r = '0;
        r0_cyc = -1; r10_cyc = -1; done_cyc = -1; n_hs = 0;
        for (int k = 0; k < c_BUDGET; k++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (hold_pending) begin
                chk("hold_valid", {127'h0, rk_valid}, 128'h1);
                chk("hold_data", rk_data, held_d);
                chk("hold_round", {124'h0, rk_round}, {124'h0, held_r});
                hold_pending = 1'b0;
            end
            rk_ready = rand_ready ? ($urandom_range(0, 9) < 3) : 1'b1;
            start    = inject && rk_valid && (rk_round == 4'd0 || rk_round == 4'd5 || rk_round == 4'd10);
            if (start) key = c_ALT;
            if (rk_valid && r0_cyc < 0) r0_cyc = cyc;
            if (rk_valid && rk_round == 4'd10 && r10_cyc < 0) r10_cyc = cyc;
            if (rk_valid) begin
                if (rk_ready) begin
                    if (n_hs < 11) begin
                        got[n_hs] = rk_data;
                        chk("round_idx", {124'h0, rk_round}, 128'(n_hs));
                    end
                    n_hs++;
                end else begin
                    hold_pending = 1'b1;
                    held_d = rk_data;
                    held_r = rk_round;
                end
            end
            tick();
        end
        start = 1'b0;
        chk("handshakes", 128'(n_hs), 128'd11);
        chk("done_seen", {127'h0, done_cyc >= 0}, 128'h1);
    endtask

    task automatic chk_all_vec1(input string tag);
        for (int i = 0; i < 11; i++) chk($sformatf("%s_rk%0d", tag, i), got[i], c_EXP1[i]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key = '0; rk_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", {127'h0, rk_valid}, 128'h0);
        chk("rst_busy",  {127'h0, busy},     128'h0);
        chk("rst_done",  {127'h0, done},     128'h0);
        chk("rst_data",  rk_data,            128'h0);
        chk("rst_round", {124'h0, rk_round}, 128'h0);
        rst = 1'b0;
        tick();

        // FIPS-197 key, consumer always ready
        rk_ready = 1'b1;
        do_start(c_KEY1);
        chk("v1_busy", {127'h0, busy}, 128'h1);
        collect(1'b0, 1'b0);
        chk_all_vec1("v1");
        chk("v1_r0_lat",   128'(r0_cyc - start_cyc),   128'd1);
        chk("v1_r10_lat",  128'(r10_cyc - start_cyc),  128'd31);
        chk("v1_done_lat", 128'(done_cyc - start_cyc), 128'd32);
        chk("v1_busy_end", {127'h0, busy}, 128'h0);
        tick();
        chk("v1_done_pulse", {127'h0, done}, 128'h0);

        // All-zero key, started the cycle after done
        do_start(128'h0);
        collect(1'b0, 1'b0);
        chk("zk_r0_lat", 128'(r0_cyc - start_cyc), 128'd1);
        chk("zk_rk0",  got[0],  128'h0);
        chk("zk_rk1",  got[1],  128'h62636363626363636263636362636363);
        chk("zk_rk10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Start in the very cycle done pulses
        do_start(c_KEY1);
        collect(1'b0, 1'b0);
        chk("dc_r0_lat", 128'(r0_cyc - start_cyc), 128'd1);
        chk_all_vec1("dc");

        // Round 0 held while consumer stalls, then random backpressure
        tick();
        rk_ready = 1'b0;
        do_start(c_KEY1);
        repeat (10) tick();
        chk("stall_valid", {127'h0, rk_valid}, 128'h1);
        chk("stall_round", {124'h0, rk_round}, 128'h0);
        chk("stall_data",  rk_data, c_KEY1);
        collect(1'b1, 1'b0);
        chk_all_vec1("bp");

        // Start with a different key injected at rounds 0, 5 and 10
        tick();
        rk_ready = 1'b1;
        do_start(c_KEY1);
        collect(1'b0, 1'b1);
        chk_all_vec1("inj");
        chk("inj_done_lat", 128'(done_cyc - start_cyc), 128'd32);

        // Reset during the MIX that follows round 4
        tick();
        rk_ready = 1'b1;
        do_start(c_KEY1);
        repeat (14) tick();
        rst = 1'b1;
        tick();
        chk("mrst_valid", {127'h0, rk_valid}, 128'h0);
        chk("mrst_busy",  {127'h0, busy},     128'h0);
        chk("mrst_round", {124'h0, rk_round}, 128'h0);
        chk("mrst_data",  rk_data,            128'h0);
        chk("mrst_done",  {127'h0, done},     128'h0);
        rst = 1'b0;
        tick();
        chk("mrst_idle", {127'h0, rk_valid}, 128'h0);
        do_start(c_KEY1);
        collect(1'b0, 1'b0);
        chk_all_vec1("post");
        chk("post_done_lat", 128'(done_cyc - start_cyc), 128'd32);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
